btn_debounce: RTL and testbench

- Debounces a single active-high mechanical push-button input for the board-level button/UI front end.
- The raw asynchronous input is synchronized to `clk`.
- A filtered level (`boton_out`) changes only after the synchronized input has held a new value for `COUNT_BOT` consecutive clock cycles.
- A one-cycle press pulse is also provided for downstream FSMs.

---
 rtl/btn_sync.sv | 34 +++
 rtl/btn_debounce.sv | 63 ++++++
 tb/tb_btn_debounce.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/btn_sync.sv
// Reset-to-zero flop chain that brings one asynchronous level into the clk domain.
// Reusable for any single-bit asynchronous input.
module btn_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Stage 0 samples the raw input; each later stage copies the one before it.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[0] <= 1'b0;
          else        sync_reg[0] <= d;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: a synchronizer, a symmetric stability counter and a
// one-cycle pulse on every accepted press.
module btn_debounce #(
  parameter int COUNT_BOT   = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton_in,
  output logic boton_out,
  output logic boton_press
);

  localparam int CNT_W = $clog2(COUNT_BOT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT_BOT - 1);

  logic             sync;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg, out_next;
  logic             press_reg, press_next;

  btn_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (boton_in),
    .q    (sync)
  );

  // Any cycle that agrees with the current level restarts the count, so
  // bounces never accumulate toward an accept.
  always_comb begin
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    press_next = 1'b0;
    if (sync == out_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_next   = '0;
      out_next   = sync;
      press_next = sync;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      press_reg <= press_next;
    end
  end

  assign boton_out   = out_reg;
  assign boton_press = press_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed checks of btn_debounce: a COUNT_BOT=16 instance for latency, bounce,
// boundary and reset cases, and a default-parameter instance for a short pulse.
module tb_btn_debounce;

  logic clk;
  logic rst_n;
  logic boton_in;
  logic boton_out;
  logic boton_press;
  logic boton_in2;
  logic boton_out2;
  logic boton_press2;

  int checks   = 0;
  int failures = 0;
  int press_cnt  = 0;
  int press_cnt2 = 0;
  int base;
  logic lvl;

  btn_debounce #(
    .COUNT_BOT  (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .boton_in   (boton_in),
    .boton_out  (boton_out),
    .boton_press(boton_press)
  );

  btn_debounce dut_dflt (
    .clk        (clk),
    .rst_n      (rst_n),
    .boton_in   (boton_in2),
    .boton_out  (boton_out2),
    .boton_press(boton_press2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (boton_press)  press_cnt++;
    if (boton_press2) press_cnt2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // Input was changed just before the next rising edge (edge 1); boton_out
  // must flip exactly on edge 'lat' and the press pulse must last one cycle.
  task automatic expect_edge(input string tag, input logic val, input int lat);
    repeat (lat - 1) @(posedge clk);
    #1 check({tag, "_before"}, 32'(boton_out), 32'(!val));
    @(posedge clk);
    #1 check({tag, "_at"}, 32'(boton_out), 32'(val));
    check({tag, "_press"}, 32'(boton_press), 32'(val));
    @(posedge clk);
    #1 check({tag, "_press_clr"}, 32'(boton_press), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    boton_in  = 1'b1;
    boton_in2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(boton_out), 32'd0);
    check("rst_press", 32'(boton_press), 32'd0);

    // Release with the button already held: full 18-edge latency.
    rst_n = 1'b1;
    expect_edge("rst_rise", 1'b1, 18);
    repeat (20) @(negedge clk);

    // Clean release then clean press.
    base = press_cnt;
    boton_in = 1'b0;
    expect_edge("release", 1'b0, 18);
    repeat (20) @(negedge clk);
    check("release_no_press", 32'(press_cnt - base), 32'd0);
    boton_in = 1'b1;
    expect_edge("press", 1'b1, 18);
    repeat (20) @(negedge clk);
    boton_in = 1'b0;
    expect_edge("release2", 1'b0, 18);
    repeat (20) @(negedge clk);

    // Bounce: toggle every 3 cycles for 60 cycles, then hold high.
    base = press_cnt;
    lvl  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      boton_in = lvl;
      repeat (3) @(negedge clk);
      lvl = ~lvl;
    end
    check("bounce_out", 32'(boton_out), 32'd0);
    check("bounce_no_press", 32'(press_cnt - base), 32'd0);
    boton_in = 1'b1;
    expect_edge("bounce_rise", 1'b1, 18);
    repeat (20) @(negedge clk);
    check("bounce_one_press", 32'(press_cnt - base), 32'd1);
    boton_in = 1'b0;
    expect_edge("bounce_fall", 1'b0, 18);
    repeat (20) @(negedge clk);

    // Boundary: 15 sampled-high cycles fall one short, 16 is just enough.
    base = press_cnt;
    boton_in = 1'b1;
    repeat (15) @(negedge clk);
    boton_in = 1'b0;
    repeat (30) @(negedge clk);
    check("pulse15_out", 32'(boton_out), 32'd0);
    check("pulse15_no_press", 32'(press_cnt - base), 32'd0);
    boton_in = 1'b1;
    fork
      begin
        repeat (16) @(negedge clk);
        boton_in = 1'b0;
      end
      expect_edge("pulse16", 1'b1, 18);
    join

    // Output is high and a release count is in progress: reset mid-count.
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_out", 32'(boton_out), 32'd0);
    check("midrst_press", 32'(boton_press), 32'd0);
    boton_in = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_hold", 32'(boton_out), 32'd0);
    rst_n = 1'b1;
    expect_edge("midrst_rise", 1'b1, 18);

    // Default COUNT_BOT: a 2500-cycle pulse is far too short to be accepted.
    @(negedge clk);
    boton_in2 = 1'b1;
    repeat (2500) @(negedge clk);
    check("dflt_during", 32'(boton_out2), 32'd0);
    boton_in2 = 1'b0;
    repeat (20) @(negedge clk);
    check("dflt_after", 32'(boton_out2), 32'd0);
    check("dflt_no_press", 32'(press_cnt2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
